// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: in-order writeback queue feeding the integer register
// file write port, plus a pending-write scoreboard for RAW hazard stalls.
module rf_writeback_unit #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic [31:0] busy,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd
);

   localparam int unsigned RD_W   = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned SUM_W  = CNT_W + 1;

   logic [RD_W-1:0]   q_rd_q   [DEPTH];
   logic [RD_W-1:0]   q_rd_d   [DEPTH];
   logic [DATA_W-1:0] q_data_q [DEPTH];
   logic [DATA_W-1:0] q_data_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              rf_we_q, rf_we_d;
   logic [RD_W-1:0]   rf_wa_q, rf_wa_d;
   logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
   logic [NREG-1:0]   busy_q, busy_d;

   logic              push_l, push_a;
   logic              do_push_l, do_push_a, do_pop;
   logic [PTR_W-1:0]  alu_idx;

   // Handshake readiness, queue push/pop and output register next state
   always_comb begin
      q_rd_d    = q_rd_q;
      q_data_d  = q_data_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rf_we_d   = 1'b0;
      rf_wa_d   = rf_wa_q;
      rf_wd_d   = rf_wd_q;
      alu_idx   = wr_ptr_q;

      // x0 results complete the handshake but never occupy a slot
      push_l    = lsu_valid && (lsu_rd != '0);
      push_a    = alu_valid && (alu_rd != '0);

      // LSU gets the last free slot; ready is based on the pre-pop count
      lsu_ready = (count_q < CNT_W'(DEPTH));
      alu_ready = ((SUM_W'(count_q) + SUM_W'(push_l)) < SUM_W'(DEPTH));

      do_push_l = push_l && lsu_ready;
      do_push_a = push_a && alu_ready;
      do_pop    = (count_q != '0);

      if (do_push_l) begin
         q_rd_d[wr_ptr_q]   = lsu_rd;
         q_data_d[wr_ptr_q] = lsu_data;
      end
      alu_idx = wr_ptr_q + PTR_W'(do_push_l);
      if (do_push_a) begin
         q_rd_d[alu_idx]   = alu_rd;
         q_data_d[alu_idx] = alu_data;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push_l) + PTR_W'(do_push_a);

      if (do_pop) begin
         rf_we_d  = 1'b1;
         rf_wa_d  = q_rd_q[rd_ptr_q];
         rf_wd_d  = q_data_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(do_push_l) + CNT_W'(do_push_a) - CNT_W'(do_pop);
   end

   // Scoreboard: issue sets, the committing write clears, set wins
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < NREG; i++) begin
         if (issue_valid && (issue_rd == RD_W'(i))) begin
            busy_d[i] = 1'b1;
         end else if (rf_we_q && (rf_wa_q == RD_W'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         q_rd_q   <= '{default: '0};
         q_data_q <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rf_we_q  <= 1'b0;
         rf_wa_q  <= '0;
         rf_wd_q  <= '0;
         busy_q   <= '0;
      end else begin
         q_rd_q   <= q_rd_d;
         q_data_q <= q_data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rf_we_q  <= rf_we_d;
         rf_wa_q  <= rf_wa_d;
         rf_wd_q  <= rf_wd_d;
         busy_q   <= busy_d;
      end
   end

   assign rf_we = rf_we_q;
   assign rf_wa = rf_wa_q;
   assign rf_wd = rf_wd_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed testbench for rf_writeback_unit.
module tb_rf_writeback_unit;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [31:0] busy;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   int n_cmp = 0;
   int n_err = 0;

   rf_writeback_unit #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .busy        (busy),
      .rf_we       (rf_we),
      .rf_wa       (rf_wa),
      .rf_wd       (rf_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid   = 1'b0;
      alu_rd      = '0;
      alu_data    = '0;
      lsu_valid   = 1'b0;
      lsu_rd      = '0;
      lsu_data    = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
      n_cmp++; if (rf_wa !== 5'd0) begin n_err++; $display("FAIL reset_wa got=%0d exp=0", rf_wa); end
      n_cmp++; if (rf_wd !== 32'd0) begin n_err++; $display("FAIL reset_wd got=%h exp=0", rf_wd); end
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL reset_busy got=%h exp=0", busy); end
      n_cmp++; if ({alu_ready, lsu_ready} !== 2'b11) begin n_err++; $display("FAIL reset_ready got=%b exp=11", {alu_ready, lsu_ready}); end
   endtask

   task automatic test_single_alu();
      issue_valid = 1'b1; issue_rd = 5'd5;
      tick();
      issue_valid = 1'b0; issue_rd = '0;
      n_cmp++; if (busy !== 32'h0000_0020) begin n_err++; $display("FAIL single_busy_set got=%h exp=00000020", busy); end
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_alu_ready got=%0b exp=1", alu_ready); end
      tick();
      alu_valid = 1'b0;
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL single_latency1 got=%0b exp=0", rf_we); end
      tick();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL single_write got=%0b/%0d/%h exp=1/5/deadbeef", rf_we, rf_wa, rf_wd); end
      n_cmp++; if (busy !== 32'h0000_0020) begin n_err++; $display("FAIL single_busy_hold got=%h exp=00000020", busy); end
      tick();
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL single_we_off got=%0b exp=0", rf_we); end
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL single_busy_clr got=%h exp=0", busy); end
   endtask

   task automatic test_simultaneous();
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
      #1;
      n_cmp++; if ({alu_ready, lsu_ready} !== 2'b11) begin n_err++; $display("FAIL simul_ready got=%b exp=11", {alu_ready, lsu_ready}); end
      tick();
      idle_inputs();
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL simul_latency got=%0b exp=0", rf_we); end
      tick();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h11}) begin n_err++; $display("FAIL simul_first got=%0b/%0d/%h exp=1/3/11", rf_we, rf_wa, rf_wd); end
      tick();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd4, 32'h22}) begin n_err++; $display("FAIL simul_second got=%0b/%0d/%h exp=1/4/22", rf_we, rf_wa, rf_wd); end
      tick();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b0, 5'd4, 32'h22}) begin n_err++; $display("FAIL simul_hold got=%0b/%0d/%h exp=0/4/22", rf_we, rf_wa, rf_wd); end
   endtask

   task automatic test_backpressure();
      logic [4:0] exp_wa [6];
      exp_wa = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8};
      // count 0 -> 2
      lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h101;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h102;
      tick();
      // count 2 -> 3 (two pushes, one pop)
      lsu_rd = 5'd3; lsu_data = 32'h103;
      alu_rd = 5'd4; alu_data = 32'h104;
      #1;
      n_cmp++; if ({alu_ready, lsu_ready} !== 2'b11) begin n_err++; $display("FAIL bp_ready_cnt2 got=%b exp=11", {alu_ready, lsu_ready}); end
      tick();
      n_cmp++; if ({rf_we, rf_wa} !== {1'b1, exp_wa[0]}) begin n_err++; $display("FAIL bp_write0 got=%0b/%0d exp=1/%0d", rf_we, rf_wa, exp_wa[0]); end
      // count 3: LSU takes the last slot, ALU stalls
      lsu_rd = 5'd7; lsu_data = 32'h107;
      alu_rd = 5'd8; alu_data = 32'h108;
      #1;
      n_cmp++; if ({alu_ready, lsu_ready} !== 2'b01) begin n_err++; $display("FAIL bp_ready_cnt3 got=%b exp=01", {alu_ready, lsu_ready}); end
      tick();
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      n_cmp++; if ({rf_we, rf_wa} !== {1'b1, exp_wa[1]}) begin n_err++; $display("FAIL bp_write1 got=%0b/%0d exp=1/%0d", rf_we, rf_wa, exp_wa[1]); end
      #1;
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL bp_alu_retry got=%0b exp=1", alu_ready); end
      tick();
      alu_valid = 1'b0;
      for (int k = 2; k < 6; k++) begin
         n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, exp_wa[k], 32'h100 + 32'(exp_wa[k])}) begin n_err++; $display("FAIL bp_write%0d got=%0b/%0d/%h exp=1/%0d", k, rf_we, rf_wa, rf_wd, exp_wa[k]); end
         tick();
      end
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL bp_drained got=%0b exp=0", rf_we); end
   endtask

   task automatic test_x0_drop();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
      issue_valid = 1'b1; issue_rd = 5'd0;
      #1;
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got=%0b exp=1", alu_ready); end
      tick();
      idle_inputs();
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL x0_busy got=%h exp=0", busy); end
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL x0_we1 got=%0b exp=0", rf_we); end
      tick();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b0, 5'd8, 32'h108}) begin n_err++; $display("FAIL x0_we2 got=%0b/%0d/%h exp=0/8/108", rf_we, rf_wa, rf_wd); end
      // LSU x0 must not steal the ALU slot at count 0
      lsu_valid = 1'b1; lsu_rd = 5'd0; alu_valid = 1'b1; alu_rd = 5'd0;
      #1;
      n_cmp++; if ({alu_ready, lsu_ready} !== 2'b11) begin n_err++; $display("FAIL x0_both_ready got=%b exp=11", {alu_ready, lsu_ready}); end
      tick();
      idle_inputs();
      tick();
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL x0_both_we got=%0b exp=0", rf_we); end
   endtask

   task automatic test_reset_mid();
      issue_valid = 1'b1; issue_rd = 5'd12;
      lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA;
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB;
      tick();
      issue_valid = 1'b0;
      lsu_rd = 5'd12; lsu_data = 32'hC;
      alu_rd = 5'd13; alu_data = 32'hD;
      tick();
      idle_inputs();
      n_cmp++; if ({rf_we, rf_wa} !== {1'b1, 5'd10}) begin n_err++; $display("FAIL mid_first got=%0b/%0d exp=1/10", rf_we, rf_wa); end
      n_cmp++; if (busy !== 32'h0000_1000) begin n_err++; $display("FAIL mid_busy got=%h exp=00001000", busy); end
      rst = 1'b1;
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h20;
      issue_valid = 1'b1; issue_rd = 5'd20;
      tick();
      rst = 1'b0;
      idle_inputs();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b0, 5'd0, 32'd0}) begin n_err++; $display("FAIL mid_rst_out got=%0b/%0d/%h exp=0/0/0", rf_we, rf_wa, rf_wd); end
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL mid_rst_busy got=%h exp=0", busy); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL mid_no_write%0d got=%0b/%0d exp=0", k, rf_we, rf_wa); end
      end
      // count 0 means the ALU is not blocked by a pending LSU push
      lsu_valid = 1'b1; lsu_rd = 5'd1;
      #1;
      n_cmp++; if ({alu_ready, lsu_ready} !== 2'b11) begin n_err++; $display("FAIL mid_ready got=%b exp=11", {alu_ready, lsu_ready}); end
      idle_inputs();
   endtask

   task automatic test_set_vs_clear();
      issue_valid = 1'b1; issue_rd = 5'd9;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      tick();
      idle_inputs();
      n_cmp++; if (busy !== 32'h0000_0200) begin n_err++; $display("FAIL svc_set got=%h exp=00000200", busy); end
      tick();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd9, 32'h99}) begin n_err++; $display("FAIL svc_write got=%0b/%0d/%h exp=1/9/99", rf_we, rf_wa, rf_wd); end
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      idle_inputs();
      n_cmp++; if (busy !== 32'h0000_0200) begin n_err++; $display("FAIL svc_set_wins got=%h exp=00000200", busy); end
      tick();
      n_cmp++; if (busy !== 32'h0000_0200) begin n_err++; $display("FAIL svc_hold got=%h exp=00000200", busy); end
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9A;
      tick();
      idle_inputs();
      tick();
      tick();
      n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL svc_clear got=%h exp=0", busy); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_alu();
      test_simultaneous();
      test_backpressure();
      test_x0_drop();
      test_reset_mid();
      test_set_vs_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
